// File: rtl/fir_avg_n_if.sv
// Sample/result bundle for fir_avg_n: flush, valid-qualified input samples,
// and the running-sum / average outputs with the window-full flag.
interface fir_avg_n_if #(
    parameter int W         = 16,
    parameter int TAPS_LOG2 = 2
);
    logic                   clr;
    logic                   in_valid;
    logic [W-1:0]           in_data;
    logic                   out_valid;
    logic [W+TAPS_LOG2-1:0] out_sum;
    logic [W-1:0]           out_avg;
    logic                   full;

    modport master (
        output clr, in_valid, in_data,
        input  out_valid, out_sum, out_avg, full
    );

    modport slave (
        input  clr, in_valid, in_data,
        output out_valid, out_sum, out_avg, full
    );
endinterface

// File: rtl/fir_avg_n.sv
// N-tap (N = 2**TAPS_LOG2) running-sum moving-average filter for unsigned samples.
// Define FIR_AVG_ROUND_EN for round-half-up averaging; default truncates.
module fir_avg_n #(
    parameter int W         = 16,
    parameter int TAPS_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    fir_avg_n_if.slave bus
);
    localparam int N  = 1 << TAPS_LOG2;
    localparam int SW = W + TAPS_LOG2;

    logic [W-1:0]         win_q [N];
    logic [W-1:0]         win_d [N];
    logic [TAPS_LOG2-1:0] ptr_q, ptr_d;
    logic [TAPS_LOG2:0]   cnt_q, cnt_d;
    logic [SW-1:0]        sum_q, sum_d;
    logic                 vld_q, vld_d;

    function automatic logic [W-1:0] avg_of(input logic [SW-1:0] s);
        logic [SW-1:0] r;
`ifdef FIR_AVG_ROUND_EN
        // Cannot overflow: N*(2**W-1) + N/2 < 2**SW.
        r = s + (SW'(1) << (TAPS_LOG2 - 1));
`else
        r = s;
`endif
        return r[SW-1:TAPS_LOG2];
    endfunction

    always_comb begin
        win_d = win_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        sum_d = sum_q;
        vld_d = 1'b0;
        if (bus.clr) begin
            for (int i = 0; i < N; i++) win_d[i] = '0;
            ptr_d = '0;
            cnt_d = '0;
            sum_d = '0;
        end else if (bus.in_valid) begin
            // The slot being overwritten is always part of sum_q, so this stays exact.
            sum_d        = sum_q + SW'(bus.in_data) - SW'(win_q[ptr_q]);
            win_d[ptr_q] = bus.in_data;
            ptr_d        = ptr_q + TAPS_LOG2'(1);
            if (!cnt_q[TAPS_LOG2]) cnt_d = cnt_q + (TAPS_LOG2 + 1)'(1);
            vld_d        = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) win_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            sum_q <= '0;
            vld_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) win_q[i] <= win_d[i];
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            sum_q <= sum_d;
            vld_q <= vld_d;
        end
    end

    // The running sum already holds through idle cycles and zeroes on flush.
    assign bus.out_valid = vld_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_avg   = avg_of(sum_q);
    assign bus.full      = cnt_q[TAPS_LOG2];
endmodule

// File: tb/tb_fir_avg_n.sv
// Randomized and directed bench for fir_avg_n against a sliding-window queue model.
module tb_fir_avg_n;
    localparam int W  = 16;
    localparam int TL = 2;
    localparam int N  = 1 << TL;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_avg_n_if #(.W(W), .TAPS_LOG2(TL)) bus ();
    fir_avg_n #(.W(W), .TAPS_LOG2(TL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    int unsigned     win[$];
    int unsigned     m_cnt;
    longint unsigned m_sum;
    logic            m_vld;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned m_avg();
`ifdef FIR_AVG_ROUND_EN
        return (m_sum + N / 2) / N;
`else
        return m_sum / N;
`endif
    endfunction

    task automatic model_reset();
        win.delete();
        m_cnt = 0;
        m_sum = 0;
        m_vld = 1'b0;
    endtask

    task automatic model_edge(input bit c, input bit v, input int unsigned d);
        if (c) begin
            model_reset();
        end else if (v) begin
            win.push_back(d);
            if (win.size() > N) void'(win.pop_front());
            if (m_cnt < N) m_cnt++;
            m_sum = 0;
            foreach (win[i]) m_sum += win[i];
            m_vld = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".vld"},  64'(bus.out_valid), 64'(m_vld));
        check({tag, ".sum"},  64'(bus.out_sum),   m_sum);
        check({tag, ".avg"},  64'(bus.out_avg),   m_avg());
        check({tag, ".full"}, 64'(bus.full),      64'(m_cnt >= N));
    endtask

    task automatic step(input string tag, input bit c, input bit v, input int unsigned d);
        bus.clr      = c;
        bus.in_valid = v;
        bus.in_data  = W'(d);
        @(posedge clk);
        model_edge(c, v, d);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        int exp1 [5] = '{1, 3, 6, 10, 14};
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step("t1", 0, 1, i + 1);
            check("t1.sum_const", 64'(bus.out_sum), 64'(exp1[i]));
            check("t1.full_const", 64'(bus.full), 64'(i >= 3));
        end

        step("t2.clr", 1, 0, 0);
        for (int i = 0; i < 4; i++) step("t2", 0, 1, 32'hFFFF);
        check("t2.sum_max", 64'(bus.out_sum), 64'h3FFFC);
        check("t2.avg_max", 64'(bus.out_avg), 64'hFFFF);
        step("t2", 0, 1, 0);
        check("t2.sum_roll", 64'(bus.out_sum), 64'h2FFFD);
        check("t2.avg_roll", 64'(bus.out_avg), 64'hBFFF);

        step("t3.clr", 1, 0, 0);
        step("t3", 0, 1, 7);
        step("t3.idle", 0, 0, 99);
        check("t3.hold", 64'(bus.out_sum), 64'd7);
        step("t3.idle", 0, 0, 99);
        step("t3", 0, 1, 9);
        check("t3.sum", 64'(bus.out_sum), 64'd16);

        step("t4.clr", 1, 0, 0);
        step("t4", 0, 1, 10);
        step("t4", 0, 1, 20);
        step("t4", 0, 1, 30);
        step("t4.clrv", 1, 1, 40);
        check("t4.clr_sum", 64'(bus.out_sum), 64'd0);
        check("t4.clr_vld", 64'(bus.out_valid), 64'd0);
        step("t4", 0, 1, 8);
        check("t4.after", 64'(bus.out_sum), 64'd8);

        step("t5.clr", 1, 0, 0);
        for (int i = 0; i < 3; i++) step("t5", 0, 1, 1);
`ifdef FIR_AVG_ROUND_EN
        check("t5.avg3", 64'(bus.out_avg), 64'd1);
`else
        check("t5.avg3", 64'(bus.out_avg), 64'd0);
`endif
        step("t5", 0, 1, 2);
        check("t5.avg5", 64'(bus.out_avg), 64'd1);

        for (int i = 0; i < 5; i++) step("t6.fill", 0, 1, $urandom_range(1, 16'hFFFF));
        bus.in_valid = 1'b0;
        @(posedge clk);
        model_edge(0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6.rst_sum",  64'(bus.out_sum),   64'd0);
        check("t6.rst_avg",  64'(bus.out_avg),   64'd0);
        check("t6.rst_vld",  64'(bus.out_valid), 64'd0);
        check("t6.rst_full", 64'(bus.full),      64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("t6", 0, 1, 4);
        step("t6", 0, 1, 4);
        check("t6.sum", 64'(bus.out_sum), 64'd8);
        check("t6.full", 64'(bus.full), 64'd0);

        for (int i = 0; i < 400; i++) begin
            int unsigned r = $urandom_range(0, 99);
            int unsigned d;
            case ($urandom_range(0, 3))
                0:       d = 32'hFFFF;
                1:       d = 0;
                default: d = $urandom_range(0, 16'hFFFF);
            endcase
            step("rnd", r < 3, r < 75, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
